ex_mdu: RTL
===========

# ex_mdu

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline. It consumes the E-stage operands (`RD1E`, `RD2E`) and the decoded operation of the instruction held in the ID/EX register. It performs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and owns the HI/LO architectural registers. Its `busy`/`start` outputs feed the hazard unit, which stalls any HI/LO-touching instruction in D while an operation is in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5, cycles from accepted MULT/MULTU to HI/LO update (≥1)
- `DIV_CYCLES`, 10, cycles from accepted DIV/DIVU to HI/LO update (≥1)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  E-stage instruction is an MDU op this cycle
- `op`  in  4  operation code (`mdu_pkg` encoding)
- `a`  in  32  rs operand (forwarded `RD1E`)
- `b`  in  32  rt operand (forwarded `RD2E`)
- `busy`  out  1  multi-cycle operation in progress
- `hi`  out  32  current HI register
- `lo`  out  32  current LO register

## Operation
- States: IDLE, RUN. Down-counter `cnt` has width `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.
- IDLE with `start=1`:
  - MULT/MULTU/DIV/DIVU: capture the 64-bit result of `a`,`b` into `pend`, load `cnt` with the op latency, go to RUN.
  - MTHI/MTLO: write `a` into `hi`/`lo` at this edge. Stay in IDLE, `busy` stays 0.
- RUN: decrement `cnt` each cycle. When `cnt==1`: write `hi<=pend[63:32]`, `lo<=pend[31:0]`, go to IDLE.
- `busy = (state==RUN)`, registered.
- `start` while RUN is ignored; the hazard unit guarantees it never happens. The bench checks that state and `pend` are unchanged.
- `op==MDU_NONE` with `start=1`: no effect.
- Arithmetic:
  - MULT: signed 32×32→64.
  - MULTU: unsigned 32×32→64.
  - DIV: quotient → LO, truncated toward zero; remainder → HI, sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (`b==0`): the operation runs its full latency, then HI/LO stay unchanged.
- `reset` (including mid-RUN): state IDLE, `cnt=0`, `busy=0`, `hi=0`, `lo=0`, `pend=0`. Any in-flight result is discarded.

## Timing
- MFHI/MFLO read `hi`/`lo` combinationally in E. No internal read latency.
- `start` sampled at edge t0 → `busy=1` during cycles t0+1 … t0+N → HI/LO updated at edge t0+N. `busy` falls at the same edge.
- An MFHI issued in D is stalled while `busy | (start & op is mul/div)`. That stall logic lives in the hazard unit, not here.
- MTHI/MTLO: the new value is visible on `hi`/`lo` the cycle after the edge.
- Back-to-back: `start` at edge t0+N (the same edge `busy` falls) is not accepted, because state is still RUN. The first acceptable edge is t0+N+1.

## Configuration
- `MDU_MADD_EN`: when defined, adds MADD (signed) and MADDU (unsigned).
  - Result is `{hi,lo} + a*b` at the accept edge.
  - Latency is `MULT_CYCLES`.
  - The HI/LO sampled at the accept edge are the ones used; a pending MTHI/MTLO cannot overlap because it would be issued later.
- When `MDU_MADD_EN` is undefined, MADD/MADDU codes behave as MDU_NONE.

## Structure
- `mdu_pkg` holds:
  - the op encoding: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8;
  - the state typedef;
  - the default latency constants.
- Sub-module `mdu_calc`: purely combinational. Takes `op`, `a`, `b`, `hi`, `lo` and produces a 64-bit result plus a `dz` flag. Sequencing stays in `ex_mdu`.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → `busy` lasts 10 cycles; hi/lo remain 0x11/0x22. Also DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- `reset` at cycle 3 of a DIV → the next cycle `busy=0`, hi=lo=0. No later update appears.
- `start` MULT pulsed again mid-RUN with different operands → ignored; the result reflects only the first operands. A new `start` one cycle after `busy` falls is accepted.
- (`MDU_MADD_EN`) hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0. Without the macro the same op leaves HI/LO unchanged and `busy=0`.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the execute-stage multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU to the long-op set).
package mdu_pkg;

  // Operation encoding carried from decode through ID/EX.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8
  } mdu_op_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_t;

  // Default latencies, in cycles from accept to HI/LO update.
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // True for ops that occupy the unit for a multi-cycle latency.
  function automatic logic mdu_is_long(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Divides use the divide latency; everything else long uses the multiply one.
  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic core of the MDU.
// Optional feature macro: MDU_MADD_EN (accumulate into {hi,lo}).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        dz
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s, r_s;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide; the one overflowing case is pinned explicitly.
  always_comb begin
    q_s = 32'd0;
    r_s = 32'd0;
    if (b == 32'd0) begin
      q_s = 32'd0;
      r_s = 32'd0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = $signed(a) / $signed(b);
      r_s = $signed(a) % $signed(b);
    end
  end

  // Select the 64-bit {hi,lo} result for the requested op.
  always_comb begin
    res = 64'd0;
    dz  = 1'b0;
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        dz  = (b == 32'd0);
        res = {r_s, q_s};
      end
      MDU_DIVU: begin
        dz = (b == 32'd0);
        if (b != 32'd0) res = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + prod_s;
      MDU_MADDU: res = {hi, lo} + prod_u;
`endif
      default: res = 64'd0;
    endcase
  end

`ifndef MDU_MADD_EN
  // HI/LO only feed the accumulate path.
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: execute-stage multiply/divide unit owning HI/LO.
// Fixed-latency sequencing around the combinational mdu_calc core.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU, MULT latency).
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t  state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat;
  logic [63:0] pend;
  logic        pend_dz;
  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res),
    .dz  (calc_dz)
  );

  assign lat = mdu_is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

  // Accept/sequence FSM; result is computed at accept and held until the latency expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MDU_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            if (mdu_is_long(op)) begin
              pend    <= calc_res;
              pend_dz <= calc_dz;
              cnt     <= lat;
              state   <= MDU_RUN;
              busy    <= 1'b1;
            end else if (op == MDU_MTHI) begin
              hi <= a;
            end else if (op == MDU_MTLO) begin
              lo <= a;
            end
          end
        end
        MDU_RUN: begin
          // New starts are ignored here; the hazard unit never issues them.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (!pend_dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
            state <= MDU_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= MDU_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
